// File: rtl/mem_stage.sv
// mem_stage: rv32 memory-access stage. Registers one EX->M bundle, runs the req/gnt/rvalid
// data bus, and retires to write-back. Define MEM_MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module mem_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [XLEN-1:0] in_aluresult,
  input  logic [XLEN-1:0] in_rbdata,
  input  logic [1:0]      in_mem_opt,
  input  logic            in_mem_signed,
  input  logic            in_mem_load,
  input  logic            in_mem_wr,
  input  logic            in_reg_wr,
  input  logic [4:0]      in_reg_wnum,
  output logic            m_stall,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_be,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            wb_valid,
  output logic            wb_reg_wr,
  output logic [4:0]      wb_reg_wnum,
  output logic [XLEN-1:0] wb_data,
  output logic            fwd_reg_wr,
  output logic [4:0]      fwd_reg_wnum,
  output logic [XLEN-1:0] fwd_data
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic            misalign_trap
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t          state;
  logic [XLEN-1:0] addr_q;
  logic [1:0]      opt_q;
  logic            signed_q;
  logic            load_q;
  logic            reg_wr_q;
  logic [4:0]      wnum_q;

  logic [XLEN-1:0] store_wdata;
  logic [3:0]      store_be;
  logic [4:0]      load_shift;
  logic [XLEN-1:0] rdata_shifted;
  logic [XLEN-1:0] load_data;
  logic            is_mem;

  assign m_stall = (state != IDLE);
  assign is_mem  = in_mem_load | in_mem_wr;

`ifdef MEM_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = (in_mem_opt == 2'b01) ? in_aluresult[0]
                    : (in_mem_opt != 2'b00) && (in_aluresult[1:0] != 2'b00);
`endif

  // Store lanes: replicate the datum so the byte enables alone pick the lane.
  always_comb begin
    store_wdata = in_rbdata;
    store_be    = 4'b1111;
    case (in_mem_opt)
      2'b00: begin
        store_wdata = {4{in_rbdata[7:0]}};
        store_be    = 4'b0001 << in_aluresult[1:0];
      end
      2'b01: begin
        store_wdata = {2{in_rbdata[15:0]}};
        store_be    = in_aluresult[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  // Halves only honour addr[1] and words ignore the low bits, matching the byte enables.
  always_comb begin
    load_shift = 5'd0;
    case (opt_q)
      2'b00:   load_shift = {addr_q[1:0], 3'b000};
      2'b01:   load_shift = {addr_q[1], 4'b0000};
      default: load_shift = 5'd0;
    endcase
    rdata_shifted = dmem_rdata >> load_shift;
    case (opt_q)
      2'b00:   load_data = signed_q ? {{24{rdata_shifted[7]}}, rdata_shifted[7:0]}
                                    : {24'b0, rdata_shifted[7:0]};
      2'b01:   load_data = signed_q ? {{16{rdata_shifted[15]}}, rdata_shifted[15:0]}
                                    : {16'b0, rdata_shifted[15:0]};
      default: load_data = rdata_shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      addr_q       <= '0;
      opt_q        <= 2'b00;
      signed_q     <= 1'b0;
      load_q       <= 1'b0;
      reg_wr_q     <= 1'b0;
      wnum_q       <= 5'd0;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_wdata   <= '0;
      dmem_be      <= 4'b0000;
      wb_valid     <= 1'b0;
      wb_reg_wr    <= 1'b0;
      wb_reg_wnum  <= 5'd0;
      wb_data      <= '0;
      fwd_reg_wr   <= 1'b0;
      fwd_reg_wnum <= 5'd0;
      fwd_data     <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_trap <= 1'b0;
`endif
    end else begin
      wb_valid <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_trap <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (in_valid) begin
            addr_q       <= in_aluresult;
            opt_q        <= in_mem_opt;
            signed_q     <= in_mem_signed;
            load_q       <= in_mem_load;
            reg_wr_q     <= in_reg_wr;
            wnum_q       <= in_reg_wnum;
            fwd_reg_wnum <= in_reg_wnum;
            fwd_data     <= in_aluresult;
            if (!is_mem) begin
              wb_valid    <= 1'b1;
              wb_reg_wr   <= in_reg_wr;
              wb_reg_wnum <= in_reg_wnum;
              wb_data     <= in_aluresult;
              fwd_reg_wr  <= in_reg_wr;
            end
`ifdef MEM_MISALIGN_TRAP_EN
            else if (misaligned) begin
              wb_valid      <= 1'b1;
              wb_reg_wr     <= 1'b0;
              wb_reg_wnum   <= in_reg_wnum;
              wb_data       <= in_aluresult;
              fwd_reg_wr    <= 1'b0;
              misalign_trap <= 1'b1;
            end
`endif
            else begin
              state      <= REQ;
              dmem_req   <= 1'b1;
              dmem_we    <= in_mem_wr;
              dmem_addr  <= {in_aluresult[XLEN-1:2], 2'b00};
              dmem_wdata <= store_wdata;
              dmem_be    <= in_mem_wr ? store_be : 4'b1111;
              fwd_reg_wr <= in_reg_wr & ~in_mem_load;
            end
          end
        end
        REQ: begin
          if (dmem_gnt) begin
            dmem_req <= 1'b0;
            if (load_q) begin
              state <= RESP;
            end else begin
              state       <= IDLE;
              wb_valid    <= 1'b1;
              wb_reg_wr   <= reg_wr_q;
              wb_reg_wnum <= wnum_q;
              wb_data     <= addr_q;
            end
          end
        end
        RESP: begin
          if (dmem_rvalid) begin
            state       <= IDLE;
            wb_valid    <= 1'b1;
            wb_reg_wr   <= reg_wr_q;
            wb_reg_wnum <= wnum_q;
            wb_data     <= load_data;
            fwd_reg_wr  <= reg_wr_q;
            fwd_data    <= load_data;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage; honours MEM_MISALIGN_TRAP_EN
// so the same bench covers both builds.
module tb_mem_stage;

  logic        clk, rst;
  logic        in_valid;
  logic [31:0] in_aluresult, in_rbdata;
  logic [1:0]  in_mem_opt;
  logic        in_mem_signed, in_mem_load, in_mem_wr, in_reg_wr;
  logic [4:0]  in_reg_wnum;
  logic        m_stall, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        wb_valid, wb_reg_wr;
  logic [4:0]  wb_reg_wnum;
  logic [31:0] wb_data;
  logic        fwd_reg_wr;
  logic [4:0]  fwd_reg_wnum;
  logic [31:0] fwd_data;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign_trap;
`endif

  int tests = 0;
  int fails = 0;

  mem_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_aluresult(in_aluresult), .in_rbdata(in_rbdata),
    .in_mem_opt(in_mem_opt), .in_mem_signed(in_mem_signed), .in_mem_load(in_mem_load),
    .in_mem_wr(in_mem_wr), .in_reg_wr(in_reg_wr), .in_reg_wnum(in_reg_wnum),
    .m_stall(m_stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_reg_wr(wb_reg_wr), .wb_reg_wnum(wb_reg_wnum), .wb_data(wb_data),
    .fwd_reg_wr(fwd_reg_wr), .fwd_reg_wnum(fwd_reg_wnum), .fwd_data(fwd_data)
`ifdef MEM_MISALIGN_TRAP_EN
    , .misalign_trap(misalign_trap)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] rb,
                       input logic [1:0] opt, input logic sgn, input logic ld,
                       input logic wr, input logic rw, input logic [4:0] wn);
    in_valid = v; in_aluresult = alu; in_rbdata = rb; in_mem_opt = opt;
    in_mem_signed = sgn; in_mem_load = ld; in_mem_wr = wr; in_reg_wr = rw; in_reg_wnum = wn;
  endtask

  task automatic run_load(input logic [31:0] addr, input logic [1:0] opt, input logic sgn,
                          input logic [4:0] wn, input logic [31:0] rdata,
                          output logic [31:0] req_addr, output logic [3:0] req_be,
                          output logic got_valid, output logic [31:0] got_data);
    drive(1'b1, addr, 32'h0, opt, sgn, 1'b1, 1'b0, 1'b1, wn);
    step();
    in_valid = 1'b0;
    req_addr = dmem_addr;
    req_be   = dmem_be;
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = rdata;
    step();
    dmem_rvalid = 1'b0;
    got_valid = wb_valid;
    got_data  = wb_data;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    step(); step();
    rst = 1'b0;
    tests++;
    if ({m_stall, dmem_req, dmem_we, wb_valid, wb_reg_wr, fwd_reg_wr} !== 6'b0) begin
      fails++;
      $display("[TB] FAIL reset_ctrl: got %b expected 000000",
               {m_stall, dmem_req, dmem_we, wb_valid, wb_reg_wr, fwd_reg_wr});
    end
    tests++;
    if ({dmem_be, dmem_addr, dmem_wdata, wb_data, fwd_data, wb_reg_wnum, fwd_reg_wnum} !== 142'b0) begin
      fails++;
      $display("[TB] FAIL reset_data: be=%b addr=%h wdata=%h wb=%h fwd=%h expected all zero",
               dmem_be, dmem_addr, dmem_wdata, wb_data, fwd_data);
    end
    drive(1'b0, 32'h0000_FFFF, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 5'd4);
    step();
    tests++;
    if ({wb_valid, fwd_reg_wr, m_stall} !== 3'b000) begin
      fails++;
      $display("[TB] FAIL idle_no_capture: got %b expected 000", {wb_valid, fwd_reg_wr, m_stall});
    end
  endtask

  task automatic test_alu();
    drive(1'b1, 32'h0000_1234, 32'h0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5);
    step();
    in_valid = 1'b0;
    tests++;
    if ({wb_valid, wb_reg_wr, wb_reg_wnum, wb_data, m_stall} !== {1'b1, 1'b1, 5'd5, 32'h0000_1234, 1'b0}) begin
      fails++;
      $display("[TB] FAIL alu_wb: valid=%b wr=%b wnum=%0d data=%h stall=%b expected 1 1 5 00001234 0",
               wb_valid, wb_reg_wr, wb_reg_wnum, wb_data, m_stall);
    end
    tests++;
    if ({fwd_reg_wr, fwd_reg_wnum, fwd_data} !== {1'b1, 5'd5, 32'h0000_1234}) begin
      fails++;
      $display("[TB] FAIL alu_fwd: wr=%b wnum=%0d data=%h expected 1 5 00001234",
               fwd_reg_wr, fwd_reg_wnum, fwd_data);
    end
    step();
    tests++;
    if ({wb_valid, m_stall} !== 2'b00) begin
      fails++;
      $display("[TB] FAIL alu_pulse: got %b expected 00", {wb_valid, m_stall});
    end
  endtask

  task automatic test_store();
    drive(1'b1, 32'h0000_0103, 32'hAABB_CCDD, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0);
    step();
    in_valid = 1'b0;
    tests++;
    if ({m_stall, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata} !==
        {1'b1, 1'b1, 1'b1, 32'h0000_0100, 4'b1000, 32'hDDDD_DDDD}) begin
      fails++;
      $display("[TB] FAIL sb_req: stall=%b req=%b we=%b addr=%h be=%b wdata=%h expected 1 1 1 00000100 1000 dddddddd",
               m_stall, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata);
    end
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    tests++;
    if ({wb_valid, dmem_req, m_stall} !== 3'b100) begin
      fails++;
      $display("[TB] FAIL sb_retire: valid/req/stall=%b expected 100", {wb_valid, dmem_req, m_stall});
    end
    step();

    drive(1'b1, 32'h0000_0102, 32'h1234_5678, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0);
    step();
    in_valid = 1'b0;
    tests++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata} !==
        {1'b1, 1'b1, 32'h0000_0100, 4'b1100, 32'h5678_5678}) begin
      fails++;
      $display("[TB] FAIL sh_req: req=%b we=%b addr=%h be=%b wdata=%h expected 1 1 00000100 1100 56785678",
               dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata);
    end
    step();
    tests++;
    if ({dmem_req, dmem_addr, dmem_be, dmem_wdata, m_stall, wb_valid} !==
        {1'b1, 32'h0000_0100, 4'b1100, 32'h5678_5678, 1'b1, 1'b0}) begin
      fails++;
      $display("[TB] FAIL sh_hold: req=%b addr=%h be=%b wdata=%h stall=%b wb=%b expected fields stable, stall 1, wb 0",
               dmem_req, dmem_addr, dmem_be, dmem_wdata, m_stall, wb_valid);
    end
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    tests++;
    if ({wb_valid, dmem_req, m_stall} !== 3'b100) begin
      fails++;
      $display("[TB] FAIL sh_retire: valid/req/stall=%b expected 100", {wb_valid, dmem_req, m_stall});
    end
    step();
  endtask

  task automatic test_load_half_delayed();
    int stalls = 0;
    int early_wb = 0;
    drive(1'b1, 32'h0000_0202, 32'h0, 2'b01, 1'b1, 1'b1, 1'b0, 1'b1, 5'd7);
    step();
    in_valid = 1'b0;
    tests++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_be, fwd_reg_wr} !== {1'b1, 1'b0, 32'h0000_0200, 4'b1111, 1'b0}) begin
      fails++;
      $display("[TB] FAIL lh_req: req=%b we=%b addr=%h be=%b fwd_wr=%b expected 1 0 00000200 1111 0",
               dmem_req, dmem_we, dmem_addr, dmem_be, fwd_reg_wr);
    end
    for (int c = 1; c <= 4; c++) begin
      if (m_stall) stalls++;
      if (wb_valid) early_wb++;
      dmem_gnt    = (c == 3);
      dmem_rvalid = (c == 2) || (c == 4);
      dmem_rdata  = (c == 2) ? 32'hDEAD_BEEF : 32'h8001_0000;
      step();
    end
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    tests++;
    if ({wb_valid, wb_reg_wr, wb_reg_wnum, wb_data, m_stall} !== {1'b1, 1'b1, 5'd7, 32'hFFFF_8001, 1'b0}) begin
      fails++;
      $display("[TB] FAIL lh_wb: valid=%b wr=%b wnum=%0d data=%h stall=%b expected 1 1 7 ffff8001 0",
               wb_valid, wb_reg_wr, wb_reg_wnum, wb_data, m_stall);
    end
    tests++;
    if (stalls !== 4 || early_wb !== 0) begin
      fails++;
      $display("[TB] FAIL lh_stall: stall cycles=%0d early wb=%0d expected 4 and 0", stalls, early_wb);
    end
    tests++;
    if ({fwd_reg_wr, fwd_reg_wnum, fwd_data} !== {1'b1, 5'd7, 32'hFFFF_8001}) begin
      fails++;
      $display("[TB] FAIL lh_fwd: wr=%b wnum=%0d data=%h expected 1 7 ffff8001",
               fwd_reg_wr, fwd_reg_wnum, fwd_data);
    end
    step();
  endtask

  task automatic test_load_byte();
    logic [31:0] ra, d;
    logic [3:0]  be;
    logic        v;
    run_load(32'h0000_0001, 2'b00, 1'b0, 5'd8, 32'h0000_F000, ra, be, v, d);
    tests++;
    if ({v, d, ra} !== {1'b1, 32'h0000_00F0, 32'h0000_0000}) begin
      fails++;
      $display("[TB] FAIL lbu: valid=%b data=%h addr=%h expected 1 000000f0 00000000", v, d, ra);
    end
    run_load(32'h0000_0001, 2'b00, 1'b1, 5'd8, 32'h0000_F000, ra, be, v, d);
    tests++;
    if ({v, d} !== {1'b1, 32'hFFFF_FFF0}) begin
      fails++;
      $display("[TB] FAIL lb: valid=%b data=%h expected 1 fffffff0", v, d);
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 32'h0000_0300, 32'h0, 2'b10, 1'b0, 1'b1, 1'b0, 1'b1, 5'd3);
    step();
    in_valid = 1'b0;
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    tests++;
    if ({m_stall, dmem_req} !== 2'b10) begin
      fails++;
      $display("[TB] FAIL rst_pre_resp: stall/req=%b expected 10", {m_stall, dmem_req});
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_5678;
    tests++;
    if ({dmem_req, m_stall, wb_valid} !== 3'b000) begin
      fails++;
      $display("[TB] FAIL rst_resp: req/stall/wb=%b expected 000", {dmem_req, m_stall, wb_valid});
    end
    step();
    dmem_rvalid = 1'b0;
    tests++;
    if ({wb_valid, m_stall} !== 2'b00) begin
      fails++;
      $display("[TB] FAIL rst_late_rvalid: wb/stall=%b expected 00", {wb_valid, m_stall});
    end

    drive(1'b1, 32'h0000_0040, 32'h0000_00AA, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0);
    step();
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    dmem_gnt = 1'b1;
    tests++;
    if ({dmem_req, m_stall} !== 2'b00) begin
      fails++;
      $display("[TB] FAIL rst_req: req/stall=%b expected 00", {dmem_req, m_stall});
    end
    step();
    dmem_gnt = 1'b0;
    tests++;
    if (wb_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL rst_late_gnt: wb_valid=%b expected 0", wb_valid);
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 32'h0000_0011, 32'h0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1);
    step();
    drive(1'b1, 32'h0000_0022, 32'h0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 5'd2);
    tests++;
    if ({wb_valid, wb_reg_wnum, wb_data} !== {1'b1, 5'd1, 32'h0000_0011}) begin
      fails++;
      $display("[TB] FAIL b2b_alu1: valid=%b wnum=%0d data=%h expected 1 1 00000011", wb_valid, wb_reg_wnum, wb_data);
    end
    step();
    tests++;
    if ({wb_valid, wb_reg_wnum, wb_data} !== {1'b1, 5'd2, 32'h0000_0022}) begin
      fails++;
      $display("[TB] FAIL b2b_alu2: valid=%b wnum=%0d data=%h expected 1 2 00000022", wb_valid, wb_reg_wnum, wb_data);
    end
    drive(1'b1, 32'h0000_0010, 32'h1122_3344, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0);
    step();
    drive(1'b1, 32'h0000_0055, 32'h0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3);
    tests++;
    if ({dmem_req, dmem_addr, dmem_be, dmem_wdata, wb_valid} !== {1'b1, 32'h0000_0010, 4'b1111, 32'h1122_3344, 1'b0}) begin
      fails++;
      $display("[TB] FAIL b2b_sw_req: req=%b addr=%h be=%b wdata=%h wb=%b expected 1 00000010 1111 11223344 0",
               dmem_req, dmem_addr, dmem_be, dmem_wdata, wb_valid);
    end
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    tests++;
    if ({wb_valid, wb_reg_wr, m_stall} !== 3'b100) begin
      fails++;
      $display("[TB] FAIL b2b_sw_wb: valid/wr/stall=%b expected 100", {wb_valid, wb_reg_wr, m_stall});
    end
    step();
    in_valid = 1'b0;
    tests++;
    if ({wb_valid, wb_reg_wr, wb_reg_wnum, wb_data} !== {1'b1, 1'b1, 5'd3, 32'h0000_0055}) begin
      fails++;
      $display("[TB] FAIL b2b_held_alu: valid=%b wr=%b wnum=%0d data=%h expected 1 1 3 00000055",
               wb_valid, wb_reg_wr, wb_reg_wnum, wb_data);
    end
    step();
    tests++;
    if (wb_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL b2b_end: wb_valid=%b expected 0", wb_valid);
    end
  endtask

  task automatic test_misalign();
`ifdef MEM_MISALIGN_TRAP_EN
    drive(1'b1, 32'h0000_0006, 32'h0, 2'b10, 1'b0, 1'b1, 1'b0, 1'b1, 5'd9);
    step();
    in_valid = 1'b0;
    tests++;
    if ({misalign_trap, wb_valid, wb_reg_wr, dmem_req, m_stall} !== 5'b11000) begin
      fails++;
      $display("[TB] FAIL lw_trap: trap/wb/wr/req/stall=%b expected 11000",
               {misalign_trap, wb_valid, wb_reg_wr, dmem_req, m_stall});
    end
    step();
    tests++;
    if ({misalign_trap, wb_valid, dmem_req} !== 3'b000) begin
      fails++;
      $display("[TB] FAIL lw_trap_pulse: trap/wb/req=%b expected 000", {misalign_trap, wb_valid, dmem_req});
    end
`else
    logic [31:0] ra, d;
    logic [3:0]  be;
    logic        v;
    run_load(32'h0000_0006, 2'b10, 1'b0, 5'd9, 32'h1234_5678, ra, be, v, d);
    tests++;
    if ({v, d, ra, be} !== {1'b1, 32'h1234_5678, 32'h0000_0004, 4'b1111}) begin
      fails++;
      $display("[TB] FAIL lw_unaligned: valid=%b data=%h addr=%h be=%b expected 1 12345678 00000004 1111",
               v, d, ra, be);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_alu();
    test_store();
    test_load_half_delayed();
    test_load_byte();
    test_reset_mid();
    test_back_to_back();
    test_misalign();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
